// File: rtl/crc16_pkg.sv
// rtl/crc16_pkg.sv - CRC16 constants, per-beat CRC function and frame FSM states
package crc16_pkg;

    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'h0000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IN_FRAME = 2'd1,
        OVERFLOW = 2'd2
    } frame_state_t;

    // MSB-first serial division of data * x^16 by the polynomial; no reflection, no final XOR.
    function automatic logic [15:0] crc16_d64(input logic [63:0] data);
        logic [15:0] crc;
        logic        fb;
        crc = CRC16_INIT;
        for (int i = 63; i >= 0; i--) begin
            fb  = data[i] ^ crc[15];
            crc = {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
        end
        return crc;
    endfunction

endpackage

// File: rtl/crc16_calc64.sv
// rtl/crc16_calc64.sv - combinational CRC16 of one 64-bit beat
import crc16_pkg::*;

module crc16_calc64 (
    input  logic [63:0] data,
    output logic [15:0] crc
);

    assign crc = crc16_d64(data);

endmodule

// File: rtl/crc16_rx_checker.sv
// rtl/crc16_rx_checker.sv - receive-side per-beat CRC16 checker with frame status and counters
import crc16_pkg::*;

module crc16_rx_checker #(
    parameter int MAX_BEATS = 256,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [63:0]      s_data,
    input  logic [15:0]      s_crc,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [63:0]      m_data,
    output logic             m_last,
    output logic             m_err,
    output logic             stat_valid,
    output logic             stat_ok,
    output logic             stat_ovf,
    output logic [CNT_W-1:0] stat_beats,
    output logic [CNT_W-1:0] stat_err_beats,
    output logic [CNT_W-1:0] frames_ok,
    output logic [CNT_W-1:0] frames_bad
);

    // Forwarded-beat counter only needs to reach MAX_BEATS; the stat counters saturate separately.
    localparam int               FW        = $clog2(MAX_BEATS + 1);
    localparam logic [FW-1:0]    FWD_LIMIT = FW'(MAX_BEATS);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic             en;
    logic             xfer;
    logic             s1_valid;
    logic             s1_last;
    logic [63:0]      s1_data;
    logic [15:0]      s1_crc;
    logic [15:0]      calc_crc;
    logic             beat_err;
    logic             forward;
    logic             finish;
    logic             frame_ok;
    frame_state_t     state_q, state_d;
    logic [FW-1:0]    fwd_q, fwd_d;
    logic [CNT_W-1:0] beats_q, beats_d;
    logic [CNT_W-1:0] errs_q, errs_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        return (inc && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
    endfunction

    // Both stages move together whenever the output slot is free or being drained.
    assign en       = !m_valid || m_ready;
    assign s_ready  = en;
    assign xfer     = en && s1_valid;
    assign beat_err = (calc_crc != s1_crc);

    crc16_calc64 u_calc (
        .data (s1_data),
        .crc  (calc_crc)
    );

    // Input stage: capture whatever is on the bus, bubbles included.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_data  <= '0;
            s1_crc   <= '0;
        end else if (en) begin
            s1_valid <= s_valid;
            s1_last  <= s_last;
            s1_data  <= s_data;
            s1_crc   <= s_crc;
        end
    end

    // Frame state and per-frame counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            fwd_q   <= '0;
            beats_q <= '0;
            errs_q  <= '0;
        end else begin
            state_q <= state_d;
            fwd_q   <= fwd_d;
            beats_q <= beats_d;
            errs_q  <= errs_d;
        end
    end

    // Next frame state, counts including the beat moving S1->S2, and whether it is forwarded.
    always_comb begin
        state_d  = state_q;
        fwd_d    = fwd_q;
        beats_d  = beats_q;
        errs_d   = errs_q;
        forward  = 1'b0;
        finish   = 1'b0;
        frame_ok = 1'b0;
        if (xfer) begin
            finish  = s1_last;
            forward = (state_q != OVERFLOW);
            if (state_q == IDLE) begin
                fwd_d   = FW'(1);
                beats_d = CNT_W'(1);
                errs_d  = CNT_W'(beat_err);
            end else begin
                beats_d = sat_inc(beats_q, 1'b1);
                errs_d  = sat_inc(errs_q, beat_err);
                if (state_q == IN_FRAME) begin
                    fwd_d = fwd_q + FW'(1);
                end
            end
            frame_ok = (errs_d == '0) && (state_q != OVERFLOW);
            if (s1_last) begin
                state_d = IDLE;
            end else if ((state_q == OVERFLOW) || (fwd_d == FWD_LIMIT)) begin
                state_d = OVERFLOW;
            end else begin
                state_d = IN_FRAME;
            end
        end
    end

    // Output stage, end-of-frame status pulse and running frame counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid        <= 1'b0;
            m_data         <= '0;
            m_last         <= 1'b0;
            m_err          <= 1'b0;
            stat_valid     <= 1'b0;
            stat_ok        <= 1'b0;
            stat_ovf       <= 1'b0;
            stat_beats     <= '0;
            stat_err_beats <= '0;
            frames_ok      <= '0;
            frames_bad     <= '0;
        end else begin
            stat_valid <= 1'b0;
            if (en) begin
                m_valid <= xfer && forward;
                m_data  <= s1_data;
                m_last  <= s1_last;
                m_err   <= beat_err;
            end
            if (finish) begin
                stat_valid     <= 1'b1;
                stat_ok        <= frame_ok;
                stat_ovf       <= (state_q == OVERFLOW);
                stat_beats     <= beats_d;
                stat_err_beats <= errs_d;
                frames_ok      <= sat_inc(frames_ok, frame_ok);
                frames_bad     <= sat_inc(frames_bad, !frame_ok);
            end
        end
    end

endmodule

// File: tb/tb_crc16_rx_checker.sv
// tb/tb_crc16_rx_checker.sv - self-checking bench for crc16_rx_checker
module tb_crc16_rx_checker;

    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic [63:0] s_data = '0;
    logic [15:0] s_crc = '0;
    logic        s_last = 1'b0;
    logic        m_ready = 1'b1;

    logic        s_ready, m_valid, m_last, m_err, stat_valid, stat_ok, stat_ovf;
    logic [63:0] m_data;
    logic [15:0] stat_beats, stat_err_beats, frames_ok, frames_bad;

    logic        s_ready2, m_valid2, m_last2, m_err2, stat_valid2, stat_ok2, stat_ovf2;
    logic [63:0] m_data2;
    logic [1:0]  stat_beats2, stat_err_beats2, frames_ok2, frames_bad2;

    crc16_rx_checker #(.MAX_BEATS(MAXB), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_crc(s_crc), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .m_err(m_err),
        .stat_valid(stat_valid), .stat_ok(stat_ok), .stat_ovf(stat_ovf),
        .stat_beats(stat_beats), .stat_err_beats(stat_err_beats),
        .frames_ok(frames_ok), .frames_bad(frames_bad)
    );

    crc16_rx_checker #(.MAX_BEATS(MAXB), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready2), .s_data(s_data), .s_crc(s_crc), .s_last(s_last),
        .m_valid(m_valid2), .m_ready(m_ready), .m_data(m_data2), .m_last(m_last2), .m_err(m_err2),
        .stat_valid(stat_valid2), .stat_ok(stat_ok2), .stat_ovf(stat_ovf2),
        .stat_beats(stat_beats2), .stat_err_beats(stat_err_beats2),
        .frames_ok(frames_ok2), .frames_bad(frames_bad2)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc_p = 0;
    bit bp_mode = 1'b0;
    logic [3:0] bp_pat = 4'b1001;

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic        err;
    } beat_t;

    typedef struct {
        int beats;
        int errs;
        bit ovf;
        bit ok;
        int fok;
        int fbad;
    } stat_t;

    beat_t exp_beats[$];
    stat_t exp_stats[$];
    int fr_cnt = 0;
    int fr_errs = 0;
    int m_fok = 0;
    int m_fbad = 0;

    // Reference CRC: long division of the 80-bit dividend data*x^16 by the 17-bit generator.
    function automatic logic [15:0] crc_ref(input logic [63:0] d);
        logic [79:0] r;
        r = {d, 16'h0000};
        for (int i = 79; i >= 16; i--) begin
            if (r[i]) r[i -: 17] = r[i -: 17] ^ 17'h18005;
        end
        return r[15:0];
    endfunction

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Downstream ready: always 1, or a 1,0,0,1 repeating pattern during the backpressure test.
    initial forever begin
        @(posedge clk);
        #1;
        m_ready = bp_mode ? bp_pat[cyc_p % 4] : 1'b1;
        cyc_p++;
    end

    // Model update on accepted beats and per-cycle comparison of both instances.
    always @(negedge clk) begin : cmp
        beat_t b;
        stat_t st;
        logic  e;
        if (rst) begin
            exp_beats.delete();
            exp_stats.delete();
            fr_cnt = 0;
            fr_errs = 0;
            m_fok = 0;
            m_fbad = 0;
        end else begin
            chk("s_ready_pair", s_ready2, s_ready);
            chk("m_valid_pair", m_valid2, m_valid);
            chk("stat_valid_pair", stat_valid2, stat_valid);
            if (m_valid && !m_ready) chk("stall_s_ready", s_ready, 1'b0);
            if (m_valid && m_ready) begin
                chk("beat_expected", exp_beats.size() != 0, 1'b1);
                if (exp_beats.size() != 0) begin
                    b = exp_beats.pop_front();
                    chk("m_data", m_data, b.data);
                    chk("m_last", m_last, b.last);
                    chk("m_err", m_err, b.err);
                    chk("m_data_pair", m_data2, m_data);
                end
            end
            if (stat_valid) begin
                chk("stat_expected", exp_stats.size() != 0, 1'b1);
                if (exp_stats.size() != 0) begin
                    st = exp_stats.pop_front();
                    chk("stat_beats", stat_beats, st.beats);
                    chk("stat_err_beats", stat_err_beats, st.errs);
                    chk("stat_ovf", stat_ovf, st.ovf);
                    chk("stat_ok", stat_ok, st.ok);
                    chk("frames_ok", frames_ok, st.fok);
                    chk("frames_bad", frames_bad, st.fbad);
                    chk("sat_stat_beats", stat_beats2, sat3(st.beats));
                    chk("sat_stat_err_beats", stat_err_beats2, sat3(st.errs));
                    chk("sat_stat_ovf", stat_ovf2, st.ovf);
                    chk("sat_stat_ok", stat_ok2, st.ok);
                    chk("sat_frames_ok", frames_ok2, sat3(st.fok));
                    chk("sat_frames_bad", frames_bad2, sat3(st.fbad));
                    if (!st.ovf) chk("stat_with_last_beat", m_valid && m_last, 1'b1);
                end
            end
            if (s_valid && s_ready) begin
                fr_cnt++;
                e = (crc_ref(s_data) != s_crc);
                if (e) fr_errs++;
                if (fr_cnt <= MAXB) begin
                    b.data = s_data;
                    b.last = s_last;
                    b.err  = e;
                    exp_beats.push_back(b);
                end
                if (s_last) begin
                    st.beats = fr_cnt;
                    st.errs  = fr_errs;
                    st.ovf   = (fr_cnt > MAXB);
                    st.ok    = (fr_errs == 0) && !st.ovf;
                    if (st.ok) m_fok++;
                    else m_fbad++;
                    st.fok  = m_fok;
                    st.fbad = m_fbad;
                    exp_stats.push_back(st);
                    fr_cnt = 0;
                    fr_errs = 0;
                end
            end
        end
    end

    // Present one beat from posedge+1 until it is accepted; returns at posedge+1 after acceptance.
    task automatic send(input logic [63:0] d, input logic [15:0] c, input logic l);
        int n;
        bit got;
        s_valid = 1'b1;
        s_data  = d;
        s_crc   = c;
        s_last  = l;
        n = 0;
        got = 1'b0;
        while (!got && n < 60) begin
            @(negedge clk);
            if (s_ready) got = 1'b1;
            else begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        if (!got) chk("send_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_beats.size() != 0 || exp_stats.size() != 0) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_in_time", n < 100, 1'b1);
    endtask

    task automatic send_good(input logic [63:0] d, input logic l);
        send(d, crc_ref(d), l);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_stat_valid", stat_valid, 1'b0);
        chk("rst_frames_ok", frames_ok, 16'h0);
        chk("rst_frames_bad", frames_bad, 16'h0);
        chk("rst_stat_beats", stat_beats, 16'h0);
        chk("rst_s_ready", s_ready, 1'b1);
        chk("model_crc_0", crc_ref(64'h0), 16'h0000);
        chk("model_crc_1", crc_ref(64'h1), 16'h8005);
        chk("model_crc_2", crc_ref(64'h2), 16'h800F);
        rst = 1'b0;

        // Single good beat: visible two cycles after acceptance together with the stat pulse.
        send(64'h1, 16'h8005, 1'b1);
        chk("t1_s1_only", m_valid, 1'b0);
        @(posedge clk);
        #1;
        chk("t1_m_valid", m_valid, 1'b1);
        chk("t1_m_err", m_err, 1'b0);
        chk("t1_stat_valid", stat_valid, 1'b1);
        drain();
        chk("t1_stat_ok", stat_ok, 1'b1);
        chk("t1_stat_beats", stat_beats, 16'd1);
        chk("t1_frames_ok", frames_ok, 16'd1);

        // Three beats, last one with a corrupted CRC.
        send(64'h0, 16'h0000, 1'b0);
        send(64'h2, 16'h800F, 1'b0);
        send(64'h1, 16'h8004, 1'b1);
        drain();
        chk("t2_stat_ok", stat_ok, 1'b0);
        chk("t2_stat_err_beats", stat_err_beats, 16'd1);
        chk("t2_frames_bad", frames_bad, 16'd1);

        // Same good frame under downstream backpressure.
        bp_mode = 1'b1;
        send(64'h0, 16'h0000, 1'b0);
        send(64'h2, 16'h800F, 1'b0);
        send(64'h1, 16'h8005, 1'b1);
        drain();
        bp_mode = 1'b0;
        chk("t3_frames_ok", frames_ok, 16'd2);
        chk("t3_stat_beats", stat_beats, 16'd3);

        // Six good beats with MAX_BEATS=4: beats 5-6 dropped, overflow flagged.
        for (int i = 1; i <= 6; i++) send_good(64'h0123_4567_89AB_CDEF * i, i == 6);
        drain();
        chk("t4_stat_ovf", stat_ovf, 1'b1);
        chk("t4_stat_beats", stat_beats, 16'd6);
        chk("t4_stat_ok", stat_ok, 1'b0);
        chk("t4_frames_bad", frames_bad, 16'd2);
        chk("t4_sat_stat_beats", stat_beats2, 2'd3);

        // Five beats, the dropped fifth one carrying a bad CRC.
        for (int i = 1; i <= 4; i++) send_good(64'hFEDC_0000_0000_0000 | 64'(i), 1'b0);
        send(64'hA5A5_5A5A_DEAD_BEEF, crc_ref(64'hA5A5_5A5A_DEAD_BEEF) ^ 16'h0100, 1'b1);
        drain();
        chk("t4b_stat_err_beats", stat_err_beats, 16'd1);
        chk("t4b_stat_ovf", stat_ovf, 1'b1);

        // Exactly MAX_BEATS beats: not an overflow.
        for (int i = 1; i <= 4; i++) send_good(64'hFFFF_FFFF_FFFF_FFF0 + 64'(i), i == 4);
        drain();
        chk("t5_stat_ok", stat_ok, 1'b1);
        chk("t5_stat_ovf", stat_ovf, 1'b0);
        chk("t5_stat_beats", stat_beats, 16'd4);
        chk("t5_frames_ok", frames_ok, 16'd3);

        // Reset two beats into a three-beat frame.
        send(64'h0, 16'h0000, 1'b0);
        send(64'h2, 16'h800F, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("t6_m_valid", m_valid, 1'b0);
        chk("t6_stat_valid", stat_valid, 1'b0);
        chk("t6_frames_ok", frames_ok, 16'h0);
        chk("t6_frames_bad", frames_bad, 16'h0);
        chk("t6_stat_err_beats", stat_err_beats, 16'h0);
        rst = 1'b0;
        chk("t6_s_ready", s_ready, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        send(64'h1, 16'h8005, 1'b1);
        drain();
        chk("t6_stat_beats", stat_beats, 16'd1);
        chk("t6_frames_ok_after", frames_ok, 16'd1);

        // Three more good frames: the 2-bit counter stops at 3.
        send_good(64'h2, 1'b1);
        send_good(64'h8000_0000_0000_0000, 1'b1);
        send_good(64'h1234_5678_9ABC_DEF0, 1'b1);
        drain();
        chk("t7_frames_ok", frames_ok, 16'd4);
        chk("t7_sat_frames_ok", frames_ok2, 2'd3);
        chk("t7_sat_frames_bad", frames_bad2, 2'd0);

        repeat (4) @(posedge clk);
        #1;
        chk("end_beats_empty", exp_beats.size(), 0);
        chk("end_stats_empty", exp_stats.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
